// File: rtl/sdram_responder.sv
// Behavioural SDRAM device: command decode, init sequencing, bank tracking, CL-delayed reads.
// Define SDRAM_RESPONDER_TIMING_CHECK_EN to add tRCD/tRP/tRFC violation checks.
module sdram_responder #(
  parameter int unsigned ROW_WIDTH    = 13,
  parameter int unsigned COL_WIDTH    = 9,
  parameter int unsigned BANK_WIDTH   = 2,
  parameter int unsigned MEM_ROW_BITS = 1,
  parameter int unsigned TRCD         = 2,
  parameter int unsigned TRP          = 2,
  parameter int unsigned TRFC         = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ROW_WIDTH-1:0]  addr,
  input  logic [BANK_WIDTH-1:0] bank_addr,
  inout  wire  [15:0]           data,
  input  logic                  clock_enable,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic                  data_mask_low,
  input  logic                  data_mask_high,
  output logic                  init_done,
  output logic                  cmd_error,
  output logic [7:0]            error_count
);

  localparam int unsigned NumBanks = 1 << BANK_WIDTH;
  localparam int unsigned MemAw    = BANK_WIDTH + MEM_ROW_BITS + COL_WIDTH;
  localparam int unsigned MemDepth = 1 << MemAw;

  localparam logic [3:0] CmdNop   = 4'b0111;
  localparam logic [3:0] CmdAct   = 4'b0011;
  localparam logic [3:0] CmdRead  = 4'b0101;
  localparam logic [3:0] CmdWrite = 4'b0100;
  localparam logic [3:0] CmdPre   = 4'b0010;
  localparam logic [3:0] CmdRef   = 4'b0001;
  localparam logic [3:0] CmdMrs   = 4'b0000;

  typedef enum logic [2:0] {StWaitPall, StWaitRef1, StWaitRef2, StWaitMrs, StReady} state_e;

  state_e                  r_state;
  logic [NumBanks-1:0]     r_open;
  logic [MEM_ROW_BITS-1:0] r_row [NumBanks];
  logic [1:0]              r_cl;
  // Read pipeline stages: {lane enables (high, low), data}; lanes 00 means empty.
  logic [17:0]             r_s0, r_s1, r_s2;
  logic [1:0]              r_oe;
  logic [15:0]             r_dout;
  logic                    r_init_done;
  logic                    r_cmd_error;
  logic [7:0]              r_err_cnt;
  logic [15:0]             r_mem [MemDepth];

  logic [3:0]       w_cmd;
  logic             w_nop;
  logic             w_mode_ok;
  logic             w_bank_open;
  logic             w_adv, w_act, w_rd, w_wr, w_pre, w_mrs, w_err;
  logic             w_tim_err;
  logic             w_err_all;
  logic [MemAw-1:0] w_idx;
  logic [17:0]      w_rd_entry;
  logic             w_unused_addr;

  assign w_cmd         = {cs_n, ras_n, cas_n, we_n};
  assign w_nop         = cs_n || (w_cmd == CmdNop);
  assign w_mode_ok     = ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && (addr[2:0] == 3'b000);
  assign w_bank_open   = r_open[bank_addr];
  assign w_idx         = {bank_addr, r_row[bank_addr], addr[COL_WIDTH-1:0]};
  assign w_rd_entry    = {~data_mask_high, ~data_mask_low, r_mem[w_idx]};
  assign w_err_all     = w_err || w_tim_err;
  assign w_unused_addr = ^addr;

  always_comb begin
    w_adv = 1'b0;
    w_act = 1'b0;
    w_rd  = 1'b0;
    w_wr  = 1'b0;
    w_pre = 1'b0;
    w_mrs = 1'b0;
    w_err = 1'b0;
    if (clock_enable && !w_nop) begin
      if (r_state != StReady) begin
        unique case (r_state)
          StWaitPall:             w_adv = (w_cmd == CmdPre) && addr[10];
          StWaitRef1, StWaitRef2: w_adv = (w_cmd == CmdRef);
          StWaitMrs:              w_adv = (w_cmd == CmdMrs) && w_mode_ok;
          default:                w_adv = 1'b0;
        endcase
        w_err = !w_adv;
        w_pre = w_adv && (r_state == StWaitPall);
        w_mrs = w_adv && (r_state == StWaitMrs);
      end else begin
        case (w_cmd)
          CmdAct: begin
            w_act = !w_bank_open;
            w_err = w_bank_open;
          end
          CmdRead: begin
            w_rd  = w_bank_open;
            w_err = !w_bank_open;
          end
          CmdWrite: begin
            // A write landing on a cycle we are driving read data still commits.
            w_wr  = w_bank_open;
            w_err = !w_bank_open || (|r_oe);
          end
          CmdPre:  w_pre = 1'b1;
          CmdRef:  w_err = |r_open;
          CmdMrs: begin
            w_mrs = w_mode_ok && !(|r_open);
            w_err = !w_mrs;
          end
          default: w_err = 1'b1;
        endcase
      end
    end
  end

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
  // Counters hold cycles since the last event, saturating; 1 on the cycle after it.
  logic [7:0] r_act_cnt [NumBanks];
  logic [7:0] r_pre_cnt [NumBanks];
  logic [7:0] r_ref_cnt;

  always_comb begin
    w_tim_err = 1'b0;
    if (clock_enable && !w_nop) begin
      if (32'(r_ref_cnt) < TRFC) w_tim_err = 1'b1;
      if (((w_cmd == CmdRead) || (w_cmd == CmdWrite)) && w_bank_open &&
          (32'(r_act_cnt[bank_addr]) < TRCD)) w_tim_err = 1'b1;
      if ((w_cmd == CmdAct) && (32'(r_pre_cnt[bank_addr]) < TRP)) w_tim_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NumBanks; i++) begin
        r_act_cnt[i] <= 8'hFF;
        r_pre_cnt[i] <= 8'hFF;
      end
      r_ref_cnt <= 8'hFF;
    end else begin
      for (int i = 0; i < NumBanks; i++) begin
        if (w_act && (bank_addr == BANK_WIDTH'(i))) r_act_cnt[i] <= 8'd1;
        else if (r_act_cnt[i] != 8'hFF)             r_act_cnt[i] <= r_act_cnt[i] + 8'd1;
        if (w_pre && (addr[10] || (bank_addr == BANK_WIDTH'(i)))) r_pre_cnt[i] <= 8'd1;
        else if (r_pre_cnt[i] != 8'hFF)                           r_pre_cnt[i] <= r_pre_cnt[i] + 8'd1;
      end
      if (clock_enable && (w_cmd == CmdRef)) r_ref_cnt <= 8'd1;
      else if (r_ref_cnt != 8'hFF)           r_ref_cnt <= r_ref_cnt + 8'd1;
    end
  end
`else
  assign w_tim_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StWaitPall;
      r_open      <= '0;
      r_cl        <= 2'd2;
      r_s0        <= '0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_oe        <= 2'b00;
      r_dout      <= '0;
      r_init_done <= 1'b0;
      r_cmd_error <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_cmd_error <= w_err_all;
      if (w_err_all && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_adv) begin
        unique case (r_state)
          StWaitPall: r_state <= StWaitRef1;
          StWaitRef1: r_state <= StWaitRef2;
          StWaitRef2: r_state <= StWaitMrs;
          StWaitMrs:  r_state <= StReady;
          default:    r_state <= r_state;
        endcase
      end
      if (w_mrs) begin
        r_cl        <= addr[5:4];
        r_init_done <= 1'b1;
      end
      if (w_act) r_open[bank_addr] <= 1'b1;
      if (w_pre) begin
        if (addr[10]) r_open            <= '0;
        else          r_open[bank_addr] <= 1'b0;
      end
      if (clock_enable) begin
        r_oe   <= r_s0[17:16];
        r_dout <= r_s0[15:0];
        r_s0   <= r_s1;
        r_s1   <= (w_rd && (r_cl == 2'd2)) ? w_rd_entry : r_s2;
        r_s2   <= (w_rd && (r_cl == 2'd3)) ? w_rd_entry : 18'd0;
      end
    end
  end

  // Backing store and open-row copies survive reset.
  always_ff @(posedge clk) begin
    if (w_act) r_row[bank_addr] <= addr[MEM_ROW_BITS-1:0];
    if (rst_n && w_wr) begin
      if (!data_mask_low)  r_mem[w_idx][7:0]  <= data[7:0];
      if (!data_mask_high) r_mem[w_idx][15:8] <= data[15:8];
    end
  end

  assign data[7:0]   = r_oe[0] ? r_dout[7:0]  : 8'hzz;
  assign data[15:8]  = r_oe[1] ? r_dout[15:8] : 8'hzz;
  assign init_done   = r_init_done;
  assign cmd_error   = r_cmd_error;
  assign error_count = r_err_cnt;

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning:
  ROW_WIDTH  13  row address bits
  COL_WIDTH  9  column address bits
  BANK_WIDTH  2  bank bits
  MEM_ROW_BITS  1  low row bits kept in backing store
  TRCD  2  min cycles ACT->READ/WRITE (timing check only)
  TRP  2  min cycles PRE->ACT same bank (timing check only)
  TRFC  7  min cycles REF->any non-NOP (timing check only)
REQ-002 SHALL provide ports, one per line: name  direction  width  meaning:
  clk  in  1  clock; all logic on rising edge
  rst_n  in  1  reset, synchronous, active-low
  addr  in  13  SDRAM address bus
  bank_addr  in  2  bank select
  data  inout  16  SDRAM data bus; driven only during read data cycles
  clock_enable  in  1  CKE
  cs_n, ras_n, cas_n, we_n  in  1 each  command strobes
  data_mask_low, data_mask_high  in  1 each  DQML/DQMH byte masks
  init_done  out  1  init sequence complete
  cmd_error  out  1  one-cycle pulse on illegal command
  error_count  out  8  saturating count of cmd_error pulses

Function
REQ-003 SHALL decode {cs_n,ras_n,cas_n,we_n} when clock_enable=1: 1xxx/0111 NOP, 0011 ACT, 0101 READ, 0100 WRITE, 0010 PRE (addr[10]=1 all banks), 0001 REF, 0000 MRS, 0110 illegal -> cmd_error.
REQ-004 SHALL ignore commands while clock_enable=0 and freeze the read pipeline.
REQ-005 SHALL run init FSM WAIT_PALL -> WAIT_REF1 -> WAIT_REF2 -> WAIT_MRS -> READY: PRE-all advances WAIT_PALL, each REF advances one REF state, MRS advances WAIT_MRS; init_done=1 only in READY.
REQ-006 SHALL flag any non-NOP command not matching the expected init step as cmd_error without changing init state.
REQ-007 SHALL latch MRS: addr[6:4] CAS latency, accepted values 2 or 3; addr[2:0] burst length must be 000; otherwise cmd_error and mode register unchanged; MRS legal in READY only with all banks closed.
REQ-008 SHALL hold per-bank open flag and open row; ACT to open bank or READ/WRITE to closed bank -> cmd_error, no other effect.
REQ-009 SHALL index backing store as {bank, row[MEM_ROW_BITS-1:0], col[COL_WIDTH-1:0]} (4096 x 16 at defaults); higher row bits alias.
REQ-010 SHALL write data on the WRITE edge, updating byte [7:0] only if data_mask_low=0 and [15:8] only if data_mask_high=0.
REQ-011 SHALL drive read data on data for exactly one cycle, starting CL cycles after the edge sampling READ; lanes whose DQM was 1 at READ stay high-Z.
REQ-012 SHALL support back-to-back READs every cycle (CL-deep pipeline); WRITE while read data due -> bus driven for read, write still performed, cmd_error pulsed.
REQ-013 SHALL close bank(s) on PRE; REF with any bank open -> cmd_error.
REQ-014 SHALL pulse cmd_error one cycle after the offending command edge; error_count increments and saturates at 255.

Reset
REQ-015 SHALL on rst_n=0 at a rising edge: init FSM to WAIT_PALL, all banks closed, CL=2, read pipeline flushed, data high-Z, init_done=0, cmd_error=0, error_count=0.
REQ-016 SHALL NOT clear backing store contents on reset; reset mid-read aborts the pending data beat.

Configuration
REQ-017 SHALL, with SDRAM_RESPONDER_TIMING_CHECK_EN defined, count cycles per bank and flag cmd_error for ACT->READ/WRITE < TRCD, PRE->ACT < TRP, REF->non-NOP < TRFC; violating command still executes.
REQ-018 SHALL, without SDRAM_RESPONDER_TIMING_CHECK_EN, omit timing counters and never flag timing violations.

Verification
REQ-019 Reset, PRE-all, REF, REF, MRS addr=0x020 -> init_done=1 after MRS edge, CL=2, error_count=0.
REQ-020 ACT bank1 row5, WRITE col3 data 0xA55A masks 00, READ col3 -> data=0xA55A exactly 2 cycles after READ edge, high-Z otherwise.
REQ-021 WRITE 0x1234 then WRITE 0xFFFF with data_mask_high=1 same column, READ -> 0x12FF.
REQ-022 MRS addr=0x030 then READ -> data 3 cycles after READ; MRS addr=0x050 -> cmd_error, CL stays 3.
REQ-023 READ to closed bank, ACT to open bank, REF before PRE-all -> three cmd_error pulses, error_count=3, no bus drive.
REQ-024 With TIMING_CHECK_EN: ACT then READ next cycle (TRCD=2) -> cmd_error pulse, data still returned after CL.
